// File: rtl/enc_pkg.sv
// Shared definitions for the 4-to-2 priority encoder with a 2-entry output buffer.
package enc_pkg;

  // {a,b} codes, identical to the select mapping of the 2x4 decoder
  localparam logic [1:0] ENC_IDX0 = 2'b00;
  localparam logic [1:0] ENC_IDX1 = 2'b01;
  localparam logic [1:0] ENC_IDX2 = 2'b10;
  localparam logic [1:0] ENC_IDX3 = 2'b11;

  localparam int IN_W    = 4;
  localparam int CODE_W  = 2;
  localparam int ENTRY_W = CODE_W + 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic a;
    logic b;
    logic zero;
    logic multi;
  } entry_t;

  function automatic logic [2:0] ones4(input logic [IN_W-1:0] w);
    ones4 = {2'b00, w[0]} + {2'b00, w[1]} + {2'b00, w[2]} + {2'b00, w[3]};
  endfunction

endpackage

// File: rtl/enc4_prio.sv
// Combinational priority encoder: highest set bit wins; flags empty and multi-hot words.
module enc4_prio
  import enc_pkg::*;
(
  input  logic [3:0] in,
  output logic       a,
  output logic       b,
  output logic       zero,
  output logic       multi
);

  logic [3:0] top;
  logic [1:0] code;

  // top[i] is set when bit i is set and no higher bit is
  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_top
      assign top[gi] = in[gi] && !(|(in >> (gi + 1)));
    end
  endgenerate

  always_comb begin
    code = ENC_IDX0;
    if (top[3])      code = ENC_IDX3;
    else if (top[2]) code = ENC_IDX2;
    else if (top[1]) code = ENC_IDX1;
  end

  assign a     = code[1];
  assign b     = code[0];
  assign zero  = (in == 4'b0000);
  assign multi = (ones4(in) > 3'd1);

endmodule

// File: rtl/encoder4x2_buf.sv
// One-hot to 2-bit encoder with valid/ready handshake and a 2-entry FIFO output buffer.
module encoder4x2_buf
  import enc_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          a,
  output logic          b,
  output logic          zero,
  output logic          multi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] err_cnt
);

  logic    enc_a, enc_b, enc_zero, enc_multi;
  entry_t  enc_entry;
  occ_t    state_reg;
  entry_t  head_reg;
  entry_t  tail_reg;
  logic    live_reg;
  logic [CW-1:0] cnt_reg;
  logic    accept;
  logic    pop;

  enc4_prio u_prio (
    .in    (in),
    .a     (enc_a),
    .b     (enc_b),
    .zero  (enc_zero),
    .multi (enc_multi)
  );

  assign enc_entry = '{a: enc_a, b: enc_b, zero: enc_zero, multi: enc_multi};

  // live_reg keeps in_ready low until the first edge after reset is released
  assign in_ready  = en && live_reg && (state_reg != ST_FULL);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head_reg is held at zero whenever the buffer is empty, so outputs need no gating
  assign a       = head_reg.a;
  assign b       = head_reg.b;
  assign zero    = head_reg.zero;
  assign multi   = head_reg.multi;
  assign err_cnt = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
      live_reg  <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      unique case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            head_reg  <= enc_entry;
            state_reg <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_reg <= enc_entry;
          end else if (accept) begin
            tail_reg  <= enc_entry;
            state_reg <= ST_FULL;
          end else if (pop) begin
            head_reg  <= '0;
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_reg  <= tail_reg;
            tail_reg  <= '0;
            state_reg <= ST_ONE;
          end
        end
        default: begin
          head_reg  <= '0;
          tail_reg  <= '0;
          state_reg <= ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (accept && (enc_entry.zero || enc_entry.multi) && (cnt_reg != {CW{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: doc/encoder4x2_buf.md
Name: encoder4x2_buf

Overview:
- Inverse of the team's 2x4 decoder. Takes a 4-bit one-hot word and produces the two select bits `a` (MSB) and `b` (LSB) that would regenerate that word through the decoder.
- Registered and buffered: a valid/ready handshake on both sides, with a 2-entry output buffer so the producer can stream without bubbles.
- Flags zero and multi-hot words, and counts them.
- Sits between one-hot status sources and any consumer of encoded 2-bit indices; its output can loop back into the decoder for self-check.

Parameters:
- CW, 8, width of the saturating error counter `err_cnt`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable; when 0, no new words are accepted.
- in  input  4  one-hot word to encode.
- in_valid  input  1  producer presents `in`.
- in_ready  output  1  block can accept `in` this cycle.
- a  output  1  encoded MSB at the buffer head.
- b  output  1  encoded LSB at the buffer head.
- zero  output  1  head entry came from `in`==0000.
- multi  output  1  head entry came from a word with more than one bit set.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry.
- err_cnt  output  CW  saturating count of accepted words with zero or multi set.

Behaviour:
- Reset (async, rst=1): buffer emptied. in_ready=0 while rst is high. a=b=zero=multi=out_valid=0, err_cnt=0. This applies at any time, including mid-transfer; held data is discarded.
- Encoding is priority, highest index wins:
  - in[3] -> a,b=1,1
  - else in[2] -> 1,0
  - else in[1] -> 0,1
  - else in[0] -> 0,0
  - in=0000 -> a,b=0,0 with zero=1.
- multi=1 when popcount(in)>1. The encoded value is still the highest set bit (e.g. 0110 -> a,b=1,0, multi=1).
- Accept: in_valid && in_ready on a rising edge.
- in_ready = en && !full and is registered-state only, with no combinational path from out_ready.
- Pop: out_valid && out_ready on a rising edge.
- Occupancy state machine, states EMPTY, ONE, FULL:
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; pop only -> EMPTY; accept and pop together -> ONE (new entry becomes head next cycle).
  - FULL: in_ready=0. Pop -> ONE.
- Latency: a word accepted at edge N is on a/b/out_valid after edge N (visible cycle N+1) when the buffer was EMPTY.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- While out_valid=0, a/b/zero/multi are 0.
- Head outputs are stable while out_valid=1 and out_ready=0.
- en=0 blocks accepts only. Stored entries continue to drain. en has no effect on out_valid.
- err_cnt increments by 1 on each accepted word with zero or multi set. It saturates at 2^CW-1 and never wraps. It is not affected by pops.

Decomposition:
- Shared package `enc_pkg`:
  - Localparams for the four codes: ENC_IDX0=2'b00 … ENC_IDX3=2'b11, matching the decoder's {a,b} mapping.
  - Occupancy state encoding: ST_EMPTY, ST_ONE, ST_FULL.
  - Entry field widths.
- One combinational sub-module `enc4_prio`: input in[3:0]; outputs a, b, zero, multi. Instantiated once at the input side, so the buffer stores encoded entries (4 bits each).
- Buffer and state machine live in the top module.

Test Plan:
- Reset, then stream 0001, 0010, 0100, 1000 with en=1 and out_ready=1 -> out_valid from cycle 1; {a,b}=00, 01, 10, 11 in order; zero=multi=0; err_cnt=0.
- out_ready=0, push three words 1000, 0100, 0010 -> first two accepted; in_ready=0 after the second. Raise out_ready -> outputs 11, then 10, then 01. The third is accepted only after the first pop.
- Inputs 0000 and 0110 -> {a,b}=00 with zero=1; {a,b}=10 with multi=1; err_cnt=2.
- en=0 with in_valid=1 while two entries are held -> in_ready=0, nothing accepted, both entries still drain on out_ready=1.
- Assert rst asynchronously mid-cycle while FULL -> outputs and err_cnt go to 0 immediately; in_ready returns to 1 on the first edge after rst falls.
- Loopback: a/b into the 2x4 decoder with en=out_valid -> decoder out equals the original one-hot input for all four codes.
